// File: rtl/set_pkg.sv
// Shared definitions for the three-circle set scanner: mode codes, FSM states,
// field positions inside the packed centre/radius buses, and the distance helper.
package set_pkg;

    localparam logic [1:0] MODE_A   = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_TWO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // LSB positions of each 4-bit coordinate in the centre bus
    localparam int XA_LSB = 20;
    localparam int YA_LSB = 16;
    localparam int XB_LSB = 12;
    localparam int YB_LSB = 8;
    localparam int XC_LSB = 4;
    localparam int YC_LSB = 0;

    // LSB positions of each 8-bit squared radius in the radius bus
    localparam int RA_LSB = 16;
    localparam int RB_LSB = 8;
    localparam int RC_LSB = 0;

    localparam logic [7:0] LAST_POS = 8'hFF;

    // Squared Euclidean distance with absolute (non-wrapping) differences.
    function automatic logic [8:0] sq_dist(input logic [3:0] px, input logic [3:0] py,
                                           input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [8:0] dx9;
        logic [8:0] dy9;
        dx  = (px >= cx) ? (px - cx) : (cx - px);
        dy  = (py >= cy) ? (py - cy) : (cy - py);
        dx9 = {5'b0, dx};
        dy9 = {5'b0, dy};
        return (dx9 * dx9) + (dy9 * dy9);
    endfunction

endpackage

// File: rtl/point_in_set.sv
// Combinational membership test of one grid position against the set region
// formed from circles A, B and C under the selected set operation.
module point_in_set
    import set_pkg::*;
(
    input  logic [23:0] central,
    input  logic [23:0] radius_square,
    input  logic [1:0]  mode,
    input  logic [7:0]  pos,
    output logic        hit
);

    logic [3:0] px;
    logic [3:0] py;
    logic       in_a;
    logic       in_b;
    logic       in_c;

    assign px = pos[7:4];
    assign py = pos[3:0];

    assign in_a = sq_dist(px, py, central[XA_LSB +: 4], central[YA_LSB +: 4])
                  <= {1'b0, radius_square[RA_LSB +: 8]};
    assign in_b = sq_dist(px, py, central[XB_LSB +: 4], central[YB_LSB +: 4])
                  <= {1'b0, radius_square[RB_LSB +: 8]};
    assign in_c = sq_dist(px, py, central[XC_LSB +: 4], central[YC_LSB +: 4])
                  <= {1'b0, radius_square[RC_LSB +: 8]};

    always_comb begin
        hit = 1'b0;
        case (mode)
            MODE_A:   hit = in_a;
            MODE_AND: hit = in_a & in_b;
            MODE_XOR: hit = in_a ^ in_b;
            MODE_TWO: hit = (in_a & in_b & ~in_c) | (in_a & ~in_b & in_c) | (~in_a & in_b & in_c);
            default:  hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/set_scan_counter.sv
// Scans all 256 positions of the 16x16 grid after a start pulse and reports how
// many lie inside the configured set region, with a one-cycle valid pulse.
module set_scan_counter
    import set_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] central,
    input  logic [23:0] radius_square,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        valid,
    output logic [8:0]  candidate
);

    state_t      state_q, state_d;
    logic [7:0]  pos_q, pos_d;
    logic [8:0]  count_q, count_d;
    logic [23:0] central_q, central_d;
    logic [23:0] radius_q, radius_d;
    logic [1:0]  mode_q, mode_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [8:0]  candidate_q, candidate_d;
    logic        hit;
    logic [8:0]  count_plus_hit;

    point_in_set u_point_in_set (
        .central       (central_q),
        .radius_square (radius_q),
        .mode          (mode_q),
        .pos           (pos_q),
        .hit           (hit)
    );

    assign count_plus_hit = count_q + {8'b0, hit};

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        count_d     = count_q;
        central_d   = central_q;
        radius_d    = radius_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        candidate_d = candidate_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    central_d = central;
                    radius_d  = radius_square;
                    mode_d    = mode;
                    pos_d     = 8'd0;
                    count_d   = 9'd0;
                    busy_d    = 1'b1;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                count_d = count_plus_hit;
                pos_d   = pos_q + 8'd1;
                // The final position's hit is folded straight into the result.
                if (pos_q == LAST_POS) begin
                    candidate_d = count_plus_hit;
                    valid_d     = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pos_q       <= 8'd0;
            count_q     <= 9'd0;
            central_q   <= 24'd0;
            radius_q    <= 24'd0;
            mode_q      <= MODE_A;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            candidate_q <= 9'd0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            count_q     <= count_d;
            central_q   <= central_d;
            radius_q    <= radius_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            candidate_q <= candidate_d;
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign candidate = candidate_q;

endmodule

// File: doc/set_scan_counter.md
# set_scan_counter

Sequential scanner that counts grid points inside a set region built from three circles A, B, C on a 16×16 integer grid. On a start pulse it latches the circle centres, squared radii and set-operation mode, then steps through all 256 positions, one per clock. Each position is tested by a combinational point evaluator, and the number of hits is reported with a one-cycle `valid` pulse. It is the driver and accumulator for the per-point membership test.

## Interface
Parameters: none. Grid is fixed at 16×16, 4-bit coordinates.

- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `en`  in  1  — start pulse; sampled only in IDLE.
- `central`  in  24  — circle centres; sampled with `en`.
  - [23:20] xA, [19:16] yA
  - [15:12] xB, [11:8] yB
  - [7:4] xC, [3:0] yC
- `radius_square`  in  24  — squared radii, unsigned; sampled with `en`.
  - [23:16] rA², [15:8] rB², [7:0] rC²
- `mode`  in  2  — set operation; sampled with `en`.
- `busy`  out  1  — scan in progress.
- `valid`  out  1  — one-cycle pulse; `candidate` is final.
- `candidate`  out  9  — hit count, 0..256.

## Operation
- FSM states: IDLE → SCAN → DONE → IDLE.
- **IDLE:** if `en`=1, latch `central`, `radius_square` and `mode`; clear `pos`=0 and `count`=0; go to SCAN.
- **SCAN:** each cycle, evaluate `pos` and add the hit to `count`.
  - `pos` is an 8-bit counter: [7:4]=x, [3:0]=y. x is the outer loop, y the inner.
  - Increment `pos` each cycle.
  - When `pos`=255 is evaluated, load `candidate` = `count` + hit and go to DONE.
- **DONE:** one cycle, then IDLE.
- Membership of a point in circle k:
  - dx = |x − xk| and dy = |y − yk|, both 4-bit unsigned.
  - No wrap-around: absolute difference, not modular.
  - d² = dx² + dy², computed at 9 bits (max 450).
  - The point is inside if d² ≤ {1'b0, rk²}.
- Hit per `mode` (latched value):
  - 00: inA
  - 01: inA & inB
  - 10: inA ^ inB
  - 11: exactly two of {inA, inB, inC}
- `count` is 9 bits and cannot overflow (at most 256).
- `en` is ignored in SCAN and DONE; there is no queuing.
- Input changes after the `en` cycle have no effect on the running scan.

## Timing
- Reset values: `busy`=0, `valid`=0, `candidate`=0; state IDLE; `pos`=0; `count`=0.
- `en` sampled at edge k:
  - `busy`=1 from edge k through edge k+256.
  - Positions 0..255 are evaluated in the cycles ending at edges k+1..k+256.
  - At edge k+256: `valid`=1, `candidate` updated, `busy`=1 (DONE state).
- At edge k+257: `valid`=0, `busy`=0. `candidate` holds its value until the next scan's DONE or reset.
- Scan latency: 256 cycles from `en` sampled to `valid` high.
- Back-to-back: minimum spacing between accepted `en` pulses is 258 cycles.
  - `en` during DONE is dropped.
  - `en` in the first IDLE cycle after DONE is accepted.
- `rst` mid-scan, at any edge:
  - Next cycle: IDLE, all outputs 0, partial count discarded.
  - `en` asserted together with `rst` is ignored.

## Structure
Shared package `set_pkg`:
- Mode encoding constants: `MODE_A`, `MODE_AND`, `MODE_XOR`, `MODE_TWO`.
- FSM state enum.
- Field-slice constants for `central` and `radius_square`.

Sub-module `point_in_set`:
- Purely combinational.
- Inputs: latched `central`, `radius_square`, `mode`, `pos`.
- Output: `hit`.
- Instantiated once.

## Test plan
- **Single point:** A=(8,8), rA²=0, mode 00 → `candidate`=1. `valid` pulses exactly 256 cycles after `en`, lasts one cycle, then `busy`=0.
- **Edge clipping:** A=(0,0), rA²=1, mode 00 → `candidate`=3, from points (0,0), (1,0), (0,1). Confirms no wrap-around.
- **Intersection and XOR:** A=(4,4), B=(5,4), rA²=rB²=1.
  - mode 01 → `candidate`=2.
  - Rerun with mode 10 → `candidate`=6.
- **Full grid and exactly-two:** A=B=C=(7,7), rA²=rB²=225.
  - mode 01 → `candidate`=256 (9-bit full count).
  - rC²=0, mode 11 → `candidate`=255.
- **Ignored `en`:**
  - `en` pulsed at cycles 50 and 256 after start, with different inputs → first result unchanged, no second scan.
  - Mid-scan input changes → no effect.
- **Reset mid-scan:** `rst` 100 cycles into a scan → `busy`=0, `valid`=0, `candidate`=0. A new `en` then completes normally with the correct count.
